nibble_serializer: RTL and testbench
====================================

Name: nibble_serializer

Overview:
- Transmit-side counterpart of the nibble-port deserializer: accepts one frame of two parallel WIDTH-bit words (f, g) via valid/ready and emits it as a 1-bit stream, LSB first, f before g.
- Downstream backpressure via out_ready.
- Programmable inter-frame gap.
- Sits between register-level producers and single-wire serial consumers.

Parameters:
- WIDTH, 4, bits per word; legal range 1..16.
- GAP_CYCLES, 1, idle cycles (out_valid=0, in_ready=0) inserted after each frame; 0 = back-to-back.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a frame on in_f/in_g.
- in_ready  output  1  block can accept a frame.
- in_f  input  WIDTH  first word, sent first.
- in_g  input  WIDTH  second word, sent second.
- out_bit  output  1  current serial bit.
- out_valid  output  1  out_bit is meaningful.
- out_last  output  1  out_bit is the final bit of the frame (g[WIDTH-1]).
- out_ready  input  1  consumer accepts out_bit this cycle.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- State machine, three states:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: frame in flight.
  - GAP: countdown between frames.
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; shift register, bit counter and gap counter =0.
  - in_ready=1 from the first cycle after rst falls.
  - out_bit=0, out_valid=0, out_last=0, busy=0.
- Accept: on a rising edge with state=IDLE and in_valid=1:
  - load shift register {in_g, in_f} (2*WIDTH bits, in_f in the low bits);
  - bit counter=0; state->SHIFT.
  - in_valid while not IDLE is ignored. The producer must hold data until in_ready; the block has no skid buffer.
- Latency: out_valid=1 in the cycle after acceptance, with out_bit=in_f[0].
- SHIFT outputs:
  - out_valid=1; out_bit=shift_reg[0].
  - out_last=1 iff bit counter==2*WIDTH-1.
  - busy=1; in_ready=0.
- Transfer occurs when out_valid&&out_ready:
  - shift register shifts right by one, zero fill; counter increments.
  - on a transfer with out_last=1: if GAP_CYCLES>0, state->GAP with gap counter=GAP_CYCLES-1; otherwise state->IDLE.
- Stall: out_ready=0 holds out_bit, out_valid and out_last stable. No bit is ever dropped or repeated.
- GAP:
  - out_valid=0, in_ready=0, busy=1.
  - gap counter decrements each cycle; at 0, state->IDLE next edge.
  - Exactly GAP_CYCLES cycles are spent in GAP.
- Back-to-back throughput with out_ready tied high: a frame of 2*WIDTH bits every 2*WIDTH+GAP_CYCLES+1 cycles (one IDLE acceptance cycle).
- Bit counter width: $clog2(2*WIDTH); no wrap is reachable (exits at 2*WIDTH-1).
- Gap counter width: $clog2(GAP_CYCLES+1), minimum 1.
- Reset mid-frame or mid-gap: frame aborted immediately (async); outputs go to reset values combinationally with rst; no partial frame resumes.
- Simultaneous in_valid with the final-bit transfer: not accepted (state is SHIFT); accepted no earlier than the IDLE cycle.
- Outputs are registered or decoded from registered state only; no combinational path from in_* or out_ready to any output.

Decomposition:
- Shared package nibble_serial_pkg holds:
  - typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_GAP} ser_state_t;
  - localparam default WIDTH=4.
  - These are reused by the matching deserializer.
- Natural sub-module: piso_shift_reg (parameterised width).
  - Inputs: load, load_data, shift_en.
  - Output: lsb.
  - The FSM and counters stay in nibble_serializer.

Test Plan:
- Reset then single frame, WIDTH=4, GAP_CYCLES=1, out_ready=1, in_f=4'hA, in_g=4'h3:
  - in_ready=1 one cycle after reset.
  - out_bit sequence 0,1,0,1,1,1,0,0 starts the cycle after acceptance.
  - out_last high only on the 8th bit.
  - exactly one gap cycle, then in_ready=1.
- Backpressure, in_f=4'h5, in_g=4'hC:
  - drive out_ready=0 for 3 cycles at bit 2 and for 2 cycles at bit 7.
  - out_bit and out_last hold stable while stalled.
  - full sequence 1,0,1,0,0,0,1,1 delivered with no drop or duplicate.
- Back-to-back, GAP_CYCLES=0, in_valid held high, two frames (0xF,0x0) then (0x0,0xF):
  - 16 valid bits with a single out_valid=0 IDLE cycle between frames.
  - per-frame period = 9 cycles.
- in_valid pulsed during SHIFT with different data:
  - ignored; in-flight frame unchanged.
  - new frame accepted only when in_ready=1.
- Async reset asserted at bit 5 of a frame (between clock edges):
  - out_valid, out_last and busy drop immediately.
  - after release, in_ready=1; next frame 0x1/0x8 serialises fully from bit 0.
- Parameter sweep WIDTH=1 and WIDTH=16 with GAP_CYCLES=3:
  - frame lengths 2 and 32 bits; out_last on the final bit.
  - busy high for exactly 2*WIDTH+3 cycles with out_ready=1.

Source files
------------

// File: rtl/nibble_serial_pkg.sv
// Shared types for the nibble-port serializer/deserializer pair.
package nibble_serial_pkg;

    typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_GAP} ser_state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Frame-in / bit-out handshake bundle of the nibble serializer.
interface nibble_serializer_if
    import nibble_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_f;
    logic [WIDTH-1:0] in_g;
    logic             out_bit;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_valid, in_f, in_g, out_ready,
        input  in_ready, out_bit, out_valid, out_last, busy
    );

    modport slave (
        input  in_valid, in_f, in_g, out_ready,
        output in_ready, out_bit, out_valid, out_last, busy
    );
endinterface

// File: rtl/nibble_serializer_piso_shift_reg.sv
// Parallel-in serial-out shift register, right shift with zero fill.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_en_i,
    output logic             lsb_o
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load takes priority; it only happens while the shifter is idle anyway.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_en_i) begin
            sr_d = sr_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb_o = sr_q[0];
endmodule

// File: rtl/nibble_serializer.sv
// Serializes a two-word frame {g, f} LSB first onto a 1-bit valid/ready stream
// with a programmable idle gap between frames.
module nibble_serializer
    import nibble_serial_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    nibble_serializer_if.slave bus
);
    localparam int unsigned FRAME_W = 2 * WIDTH;
    localparam int unsigned CNT_W   = cnt_width(FRAME_W);
    localparam int unsigned GAP_W   = cnt_width(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_t       state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             accept;
    logic             xfer;
    logic             shift_lsb;

    assign accept = (state_q == SER_IDLE) && bus.in_valid;
    assign xfer   = (state_q == SER_SHIFT) && bus.out_ready;

    piso_shift_reg #(
        .WIDTH (FRAME_W)
    ) u_piso (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .load_data_i ({bus.in_g, bus.in_f}),
        .shift_en_i  (xfer),
        .lsb_o       (shift_lsb)
    );

    // Frame sequencing: accept in IDLE, count bits in SHIFT, count down in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SER_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            unique case (state_q)
                SER_IDLE: begin
                    if (bus.in_valid) begin
                        state_q   <= SER_SHIFT;
                        bit_cnt_q <= '0;
                    end
                end
                SER_SHIFT: begin
                    if (bus.out_ready) begin
                        if (bit_cnt_q == LAST_IDX) begin
                            if (GAP_CYCLES > 0) begin
                                state_q   <= SER_GAP;
                                gap_cnt_q <= GAP_LOAD;
                            end else begin
                                state_q <= SER_IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                SER_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= SER_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_q <= SER_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state; the shifter reads zero outside a frame.
    assign bus.in_ready  = (state_q == SER_IDLE);
    assign bus.out_valid = (state_q == SER_SHIFT);
    assign bus.out_last  = (state_q == SER_SHIFT) && (bit_cnt_q == LAST_IDX);
    assign bus.out_bit   = shift_lsb;
    assign bus.busy      = (state_q != SER_IDLE);
endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: four parameterisations checked against a bit-list model.
module tb_nibble_serializer;

    logic clk;
    logic rst;

    logic        in_valid  [4];
    logic [15:0] in_f      [4];
    logic [15:0] in_g      [4];
    logic        out_ready [4];
    logic        ob [4];
    logic        ov [4];
    logic        ol [4];
    logic        ir [4];
    logic        bz [4];

    int wtab [4] = '{4, 4, 1, 16};
    int gtab [4] = '{1, 0, 3, 3};

    int checks = 0;
    int errors = 0;

    nibble_serializer_if #(.WIDTH(4))  if0 ();
    nibble_serializer_if #(.WIDTH(4))  if1 ();
    nibble_serializer_if #(.WIDTH(1))  if2 ();
    nibble_serializer_if #(.WIDTH(16)) if3 ();

    nibble_serializer #(.WIDTH(4),  .GAP_CYCLES(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    nibble_serializer #(.WIDTH(4),  .GAP_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    nibble_serializer #(.WIDTH(1),  .GAP_CYCLES(3)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    nibble_serializer #(.WIDTH(16), .GAP_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    assign if0.in_valid = in_valid[0]; assign if0.in_f = in_f[0][3:0]; assign if0.in_g = in_g[0][3:0];
    assign if1.in_valid = in_valid[1]; assign if1.in_f = in_f[1][3:0]; assign if1.in_g = in_g[1][3:0];
    assign if2.in_valid = in_valid[2]; assign if2.in_f = in_f[2][0:0]; assign if2.in_g = in_g[2][0:0];
    assign if3.in_valid = in_valid[3]; assign if3.in_f = in_f[3];      assign if3.in_g = in_g[3];
    assign if0.out_ready = out_ready[0];
    assign if1.out_ready = out_ready[1];
    assign if2.out_ready = out_ready[2];
    assign if3.out_ready = out_ready[3];

    assign ob[0] = if0.out_bit; assign ov[0] = if0.out_valid; assign ol[0] = if0.out_last;
    assign ir[0] = if0.in_ready; assign bz[0] = if0.busy;
    assign ob[1] = if1.out_bit; assign ov[1] = if1.out_valid; assign ol[1] = if1.out_last;
    assign ir[1] = if1.in_ready; assign bz[1] = if1.busy;
    assign ob[2] = if2.out_bit; assign ov[2] = if2.out_valid; assign ol[2] = if2.out_last;
    assign ir[2] = if2.in_ready; assign bz[2] = if2.busy;
    assign ob[3] = if3.out_bit; assign ov[3] = if3.out_valid; assign ol[3] = if3.out_last;
    assign ir[3] = if3.in_ready; assign bz[3] = if3.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bit k of a frame is f[k] for the first w bits, then g[k-w].
    function automatic logic exp_bit(input logic [15:0] f, input logic [15:0] g,
                                     input int w, input int k);
        return (k < w) ? f[k] : g[k - w];
    endfunction

    function automatic int stall_len(input int k, input int sa, input int la,
                                     input int sb, input int lb, input bit rnd);
        if (k == sa) return la;
        if (k == sb) return lb;
        return rnd ? int'($urandom_range(0, 2)) : 0;
    endfunction

    // Sends one frame on DUT d and checks every cycle until it is idle again.
    // Called and returns at a falling edge with the DUT idle.
    task automatic run_frame(input int d, input logic [15:0] f, input logic [15:0] g,
                             input int sa, input int la, input int sb, input int lb,
                             input bit rnd, input int pulse_bit, input int abort_bit);
        int  w = wtab[d];
        int  gap = gtab[d];
        int  k = 0;
        int  cyc = 0;
        int  stl;
        int  stalls = 0;
        int  busy_n = 0;
        bit  pulsed = 1'b0;
        chk("idle_in_ready", ir[d], 1);
        chk("idle_out_valid", ov[d], 0);
        in_valid[d]  = 1'b1;
        in_f[d]      = f;
        in_g[d]      = g;
        out_ready[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        stl = stall_len(0, sa, la, sb, lb, rnd);
        while (k < 2 * w && cyc < 400) begin
            if (k == abort_bit) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_out_valid", ov[d], 0);
                chk("abort_out_last", ol[d], 0);
                chk("abort_busy", bz[d], 0);
                chk("abort_out_bit", ob[d], 0);
                @(negedge clk);
                rst = 1'b0;
                out_ready[d] = 1'b1;
                return;
            end
            chk("shift_out_valid", ov[d], 1);
            chk("shift_out_bit", ob[d], exp_bit(f, g, w, k));
            chk("shift_out_last", ol[d], (k == 2 * w - 1) ? 1 : 0);
            chk("shift_in_ready", ir[d], 0);
            if (bz[d]) busy_n++;
            if (k == pulse_bit && !pulsed) begin
                in_valid[d] = 1'b1;
                in_f[d]     = ~f;
                in_g[d]     = ~g;
                pulsed      = 1'b1;
            end else begin
                in_valid[d] = 1'b0;
            end
            out_ready[d] = (stl == 0);
            @(negedge clk);
            if (stl == 0) begin
                k++;
                stl = stall_len(k, sa, la, sb, lb, rnd);
            end else begin
                stl--;
                stalls++;
            end
            cyc++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        chk("frame_bits_sent", k, 2 * w);
        for (int i = 0; i < gap; i++) begin
            chk("gap_out_valid", ov[d], 0);
            chk("gap_in_ready", ir[d], 0);
            chk("gap_busy", bz[d], 1);
            if (bz[d]) busy_n++;
            @(negedge clk);
        end
        chk("post_in_ready", ir[d], 1);
        chk("post_out_valid", ov[d], 0);
        chk("post_busy", bz[d], 0);
        chk("busy_cycles", busy_n, 2 * w + gap + stalls);
    endtask

    logic exp_q [$];

    initial begin
        int idx;
        int d;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_f[i]      = '0;
            in_g[i]      = '0;
            out_ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out_bit", ob[0], 0);
        chk("rst_out_last", ol[0], 0);
        chk("rst_busy", bz[3], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", ir[0], 1);

        // Single frame A/3, then a backpressured frame 5/C.
        run_frame(0, 16'hA, 16'h3, -1, 0, -1, 0, 1'b0, -1, -1);
        run_frame(0, 16'h5, 16'hC, 2, 3, 7, 2, 1'b0, -1, -1);

        // Back-to-back on the gapless instance with in_valid held high.
        chk("b2b_in_ready", ir[1], 1);
        for (int k = 0; k < 8; k++) exp_q.push_back(exp_bit(16'hF, 16'h0, 4, k));
        for (int k = 0; k < 8; k++) exp_q.push_back(exp_bit(16'h0, 16'hF, 4, k));
        in_f[1] = 16'hF; in_g[1] = 16'h0; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
        @(negedge clk);
        in_f[1] = 16'h0; in_g[1] = 16'hF;
        idx = 0;
        for (int c = 0; c < 17; c++) begin
            if (c == 8) begin
                chk("b2b_idle_valid", ov[1], 0);
                chk("b2b_idle_ready", ir[1], 1);
            end else begin
                chk("b2b_valid", ov[1], 1);
                chk("b2b_bit", ob[1], exp_q[idx]);
                chk("b2b_last", ol[1], (idx == 7 || idx == 15) ? 1 : 0);
                idx++;
            end
            if (c == 9) in_valid[1] = 1'b0;
            @(negedge clk);
        end
        chk("b2b_end_valid", ov[1], 0);
        chk("b2b_end_ready", ir[1], 1);

        // in_valid pulses while shifting, including on the final-bit transfer.
        run_frame(0, 16'h9, 16'h6, -1, 0, -1, 0, 1'b0, 3, -1);
        run_frame(1, 16'h2, 16'hB, -1, 0, -1, 0, 1'b0, 7, -1);
        run_frame(1, 16'hE, 16'h4, -1, 0, -1, 0, 1'b0, -1, -1);

        // Asynchronous abort at bit 5, then a clean frame 1/8.
        run_frame(0, 16'h6, 16'h9, -1, 0, -1, 0, 1'b0, -1, 5);
        chk("after_abort_in_ready", ir[0], 1);
        run_frame(0, 16'h1, 16'h8, -1, 0, -1, 0, 1'b0, -1, -1);

        // Width extremes.
        run_frame(2, 16'h1, 16'h0, -1, 0, -1, 0, 1'b0, -1, -1);
        run_frame(2, 16'h0, 16'h1, -1, 0, -1, 0, 1'b0, -1, -1);
        run_frame(3, 16'hA5C3, 16'h1234, -1, 0, -1, 0, 1'b0, -1, -1);

        // Random frames with random stalls.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = 1;
                2:       d = 2;
                default: d = 3;
            endcase
            run_frame(d, 16'($urandom), 16'($urandom), -1, 0, -1, 0, 1'b1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
